// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs fields plus a full immediate into one word, expands LI to ADDI or LUI+ADDI.
// Define INST_ENC_ERR_CNT_EN to add the saturating err_count output.
module inst_encoder #(
  parameter int         XLEN       = 32,
  parameter logic [6:0] LI_OP_LUI  = 7'b0110111,
  parameter logic [6:0] LI_OP_ADDI = 7'b0010011
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_fmt,
  input  logic [6:0]      in_opcode,
  input  logic [4:0]      in_rd,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [2:0]      in_funct3,
  input  logic [6:0]      in_funct7,
  input  logic [XLEN-1:0] in_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_inst,
  output logic            out_last,
  output logic            out_err
`ifdef INST_ENC_ERR_CNT_EN
  ,
  output logic [15:0]     err_count
`endif
);

  typedef enum logic [0:0] {IDLE = 1'b0, LI_2 = 1'b1} state_t;

  localparam logic [2:0] FMT_R  = 3'd0;
  localparam logic [2:0] FMT_I  = 3'd1;
  localparam logic [2:0] FMT_S  = 3'd2;
  localparam logic [2:0] FMT_B  = 3'd3;
  localparam logic [2:0] FMT_U  = 3'd4;
  localparam logic [2:0] FMT_J  = 3'd5;
  localparam logic [2:0] FMT_LI = 3'd6;

  // Handshake: a transfer happens on a rising edge where valid && ready; ready never looks at valid.
  state_t          state, state_next;
  logic            accept, li_load;
  logic [XLEN-1:0] enc_inst;
  logic            enc_err, enc_two;
  logic [XLEN-1:0] li_sum;
  logic [11:0]     li_lo_q;
  logic [4:0]      li_rd_q;
  logic            sx11, sx12, sx20;

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  // In LI_2 the first word is always valid, so out_ready alone marks its hand-off.
  assign li_load  = (state == LI_2) && out_ready;

  assign li_sum = in_imm + 32'h0000_0800;
  assign sx11   = (&in_imm[31:11]) || !(|in_imm[31:11]);
  assign sx12   = (&in_imm[31:12]) || !(|in_imm[31:12]);
  assign sx20   = (&in_imm[31:20]) || !(|in_imm[31:20]);

  always_comb begin
    enc_inst = '0;
    enc_err  = 1'b0;
    enc_two  = 1'b0;
    case (in_fmt)
      FMT_R: enc_inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      FMT_I: begin
        enc_err  = !sx11;
        enc_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      end
      FMT_S: begin
        enc_err  = !sx11;
        enc_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      end
      FMT_B: begin
        enc_err  = !sx12 || in_imm[0];
        enc_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], in_opcode};
      end
      FMT_U: begin
        enc_err  = |in_imm[11:0];
        enc_inst = {in_imm[31:12], in_rd, in_opcode};
      end
      FMT_J: begin
        enc_err  = !sx20 || in_imm[0];
        enc_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
      end
      FMT_LI: begin
        if (sx11) begin
          enc_inst = {in_imm[11:0], 5'd0, 3'b000, in_rd, LI_OP_ADDI};
        end else begin
          // hi is rounded so that the sign-extended ADDI of lo lands on the exact value.
          enc_inst = {li_sum[31:12], in_rd, LI_OP_LUI};
          enc_two  = |in_imm[11:0];
        end
      end
      default: enc_err = 1'b1;
    endcase
    if (enc_err) enc_inst = '0;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && enc_two) state_next = LI_2;
      LI_2:    if (li_load) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_inst  <= '0;
      out_last  <= 1'b0;
      out_err   <= 1'b0;
      li_lo_q   <= '0;
      li_rd_q   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_inst  <= enc_inst;
      out_last  <= !enc_two;
      out_err   <= enc_err;
      li_lo_q   <= in_imm[11:0];
      li_rd_q   <= in_rd;
    end else if (li_load) begin
      out_valid <= 1'b1;
      out_inst  <= {li_lo_q, li_rd_q, 3'b000, li_rd_q, LI_OP_ADDI};
      out_last  <= 1'b1;
      out_err   <= 1'b0;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef INST_ENC_ERR_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count <= '0;
    end else if (out_valid && out_ready && out_err && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: hand-computed words go through an expected queue, one check task.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid, out_ready, out_last, out_err;
  logic [31:0] out_inst;
`ifdef INST_ENC_ERR_CNT_EN
  logic [15:0] err_count;
`endif

  int          n_tests = 0;
  int          n_fail  = 0;
  int          err_exp = 0;
  logic [31:0] exp_q[$];
  logic [31:0] held;

  inst_encoder dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_last(out_last), .out_err(out_err)
`ifdef INST_ENC_ERR_CNT_EN
    , .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm);
    in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send(input string tag, input logic [2:0] fmt, input logic [6:0] op,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
    int waited;
    waited = 0;
    drive(fmt, op, rd, rs1, rs2, f3, f7, imm);
    in_valid = 1'b1;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited == 20) check({tag, " accept"}, {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic collect(input string tag, input logic last, input logic err);
    logic [31:0] exp;
    exp = exp_q.pop_front();
    check({tag, " valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, " inst"},  out_inst, exp);
    check({tag, " last"},  {31'b0, out_last}, {31'b0, last});
    check({tag, " err"},   {31'b0, out_err},  {31'b0, err});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    if (err) err_exp++;
  endtask

  task automatic one(input string tag, input logic [2:0] fmt, input logic [6:0] op,
                     input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                     input logic [31:0] exp_inst, input logic err);
    exp_q.push_back(exp_inst);
    send(tag, fmt, op, rd, rs1, rs2, f3, f7, imm);
    collect(tag, 1'b1, err);
    check({tag, " drained"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    drive(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    repeat (2) @(negedge clk);
    check("rst out_valid", {31'b0, out_valid}, 32'd0);
    check("rst out_inst",  out_inst, 32'd0);
    check("rst out_last",  {31'b0, out_last}, 32'd0);
    check("rst out_err",   {31'b0, out_err}, 32'd0);
    check("rst in_ready",  {31'b0, in_ready}, 32'd1);
    reset = 1'b0;
    @(negedge clk);

    one("addi",     3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,          32'h0050_0093, 1'b0);
    one("i_min",    3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800,  32'h8000_0093, 1'b0);
    one("add",      3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd3,         32'h0020_81B3, 1'b0);
    one("sub",      3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hFFFF_FFFF, 32'h4020_81B3, 1'b0);
    one("sw",       3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,          32'h0020_A423, 1'b0);
    one("sw_neg",   3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'hFFFF_FFFF,  32'hFE20_AFA3, 1'b0);
    one("beq",      3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC,  32'hFE20_8EE3, 1'b0);
    one("lui",      3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000,  32'h1234_52B7, 1'b0);
    one("jal",      3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,       32'h0010_00EF, 1'b0);
    one("li_lui",   3'd6, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1000,  32'h0000_12B7, 1'b0);
    one("li_neg1",  3'd6, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF,  32'hFFF0_0293, 1'b0);

    // Two-word LI with a stalled consumer on the first word.
    exp_q.push_back(32'h1234_62B7);
    send("li2", 3'd6, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5FFF);
    held = out_inst;
    in_valid = 1'b1;
    drive(3'd1, 7'h13, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("li2 hold in_ready", {31'b0, in_ready}, 32'd0);
      @(negedge clk);
      check("li2 hold inst", out_inst, held);
      check("li2 hold valid", {31'b0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    collect("li2 w1", 1'b0, 1'b0);
    exp_q.push_back(32'hFFF2_8293);
    collect("li2 w2", 1'b1, 1'b0);
    check("li2 drained", {31'b0, out_valid}, 32'd0);

    // Reset while the second LI word is pending.
    send("li_rst", 3'd6, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5FFF);
    check("li_rst w1 valid", {31'b0, out_valid}, 32'd1);
    reset = 1'b1;
    #1;
    check("li_rst async valid", {31'b0, out_valid}, 32'd0);
    check("li_rst async inst",  out_inst, 32'd0);
    err_exp = 0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("li_rst no w2", {31'b0, out_valid}, 32'd0);
    check("li_rst in_ready", {31'b0, in_ready}, 32'd1);
    one("post_rst", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093, 1'b0);

    // Range errors.
    one("i_big",    3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,      32'd0, 1'b1);
    one("b_odd",    3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd5,         32'd0, 1'b1);
    one("b_range",  3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd4096,      32'd0, 1'b1);
    one("u_low",    3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001, 32'd0, 1'b1);
    one("j_odd",    3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3,         32'd0, 1'b1);
    one("fmt7",     3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0,         32'd0, 1'b1);

    // Back-to-back with the consumer always ready.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    @(negedge clk);
    check("b2b a inst", out_inst, 32'h0050_0093);
    check("b2b in_ready", {31'b0, in_ready}, 32'd1);
    drive(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0);
    @(negedge clk);
    check("b2b b inst", out_inst, 32'h4020_81B3);
    check("b2b b valid", {31'b0, out_valid}, 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b drained", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b0;

`ifdef INST_ENC_ERR_CNT_EN
    check("err_count", {16'b0, err_count}, err_exp[31:0]);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
